// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache in front of a 256-bit line memory.
// Hits complete in the same cycle; misses stall the pipeline through writeback and refill.
module dcache_ctrl #(
    parameter int unsigned INDEX_W = 5,
    parameter int unsigned TAG_W   = 22
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         p1_MemRead_i,
    input  logic         p1_MemWrite_i,
    input  logic [31:0]  p1_addr_i,
    input  logic [31:0]  p1_data_i,
    output logic [31:0]  p1_data_o,
    output logic         p1_stall_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i
);

    localparam int unsigned LINES = 2 ** INDEX_W;

    typedef enum logic [1:0] {StIdle, StWriteback, StAllocate, StRefill} state_e;

    state_e             state_q;
    logic [LINES-1:0]   valid_q;
    logic [LINES-1:0]   dirty_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [255:0]       data_q [LINES];

    logic [2:0]         word;
    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic               req;
    logic               is_write;
    logic               is_read;
    logic               hit;
    logic               wr_hit;
    logic [255:0]       line;
    logic               unused_addr_bits;

    assign word     = p1_addr_i[4:2];
    assign index    = p1_addr_i[4+INDEX_W:5];
    assign tag      = p1_addr_i[31:5+INDEX_W];
    assign req      = p1_MemRead_i | p1_MemWrite_i;
    assign is_write = p1_MemWrite_i;
    assign is_read  = p1_MemRead_i & ~p1_MemWrite_i;
    assign line     = data_q[index];
    assign hit      = valid_q[index] && (tag_q[index] == tag);
    assign wr_hit   = (state_q == StIdle) && is_write && hit;

    assign unused_addr_bits = ^p1_addr_i[1:0];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req && !hit) begin
                        state_q <= (valid_q[index] && dirty_q[index]) ? StWriteback : StAllocate;
                    end else if (wr_hit) begin
                        dirty_q[index] <= 1'b1;
                    end
                end
                StWriteback: begin
                    if (mem_ack_i) state_q <= StAllocate;
                end
                StAllocate: begin
                    if (mem_ack_i) begin
                        state_q        <= StRefill;
                        valid_q[index] <= 1'b1;
                        dirty_q[index] <= 1'b0;
                    end
                end
                StRefill: state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase
        end
    end

    // Tag and data arrays carry no reset; valid bits gate every use of them.
    always_ff @(posedge clk_i) begin
        if (state_q == StAllocate && mem_ack_i) begin
            data_q[index] <= mem_data_i;
            tag_q[index]  <= tag;
        end else if (wr_hit) begin
            data_q[index][{word, 5'b00000} +: 32] <= p1_data_i;
        end
    end

    always_comb begin
        p1_stall_o   = 1'b0;
        p1_data_o    = '0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        unique case (state_q)
            StIdle: begin
                p1_stall_o = req & ~hit;
                if (is_read && hit) p1_data_o = line[{word, 5'b00000} +: 32];
            end
            StWriteback: begin
                p1_stall_o   = 1'b1;
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {tag_q[index], index, 5'b00000};
                mem_data_o   = line;
            end
            StAllocate: begin
                p1_stall_o   = 1'b1;
                mem_enable_o = 1'b1;
                mem_addr_o   = {tag, index, 5'b00000};
            end
            StRefill: p1_stall_o = 1'b1;
            default: p1_stall_o = 1'b0;
        endcase
        // A pending request must not hold the pipeline frozen while reset is asserted.
        if (!rst_i) p1_stall_o = 1'b0;
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: latency-programmable line memory, an address-level
// reference model of the cache, and a per-cycle compare process.
module tb_dcache_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         p1_MemRead_i = 1'b0;
    logic         p1_MemWrite_i = 1'b0;
    logic [31:0]  p1_addr_i = '0;
    logic [31:0]  p1_data_i = '0;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i = '0;
    logic         mem_ack_i;

    dcache_ctrl #(.INDEX_W(5), .TAG_W(22)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .p1_MemRead_i  (p1_MemRead_i),
        .p1_MemWrite_i (p1_MemWrite_i),
        .p1_addr_i     (p1_addr_i),
        .p1_data_i     (p1_data_i),
        .p1_data_o     (p1_data_o),
        .p1_stall_o    (p1_stall_o),
        .mem_enable_o  (mem_enable_o),
        .mem_write_o   (mem_write_o),
        .mem_addr_o    (mem_addr_o),
        .mem_data_o    (mem_data_o),
        .mem_data_i    (mem_data_i),
        .mem_ack_i     (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'h0000_0404) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]} ^ 32'h0F0F_0000;
    endfunction

    function automatic logic [255:0] init_line(input logic [31:0] la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[32*w +: 32] = init_word(la + 32'(4 * w));
        return l;
    endfunction

    // Line memory: acks on the lat-th cycle of each request.
    logic [255:0] dram [int];
    int   lat = 3;
    int   cnt = 0;
    logic mdl_ack = 1'b0;
    logic spur_ack = 1'b0;
    assign mem_ack_i = mdl_ack | spur_ack;

    always @(negedge clk_i) begin
        if (mdl_ack) begin
            mdl_ack = 1'b0;
            cnt = 0;
        end
        if (!mem_enable_o) begin
            cnt = 0;
        end else begin
            cnt++;
            if (cnt == lat) begin
                mdl_ack = 1'b1;
                if (mem_write_o) dram[int'(mem_addr_o >> 5)] = mem_data_o;
                else if (dram.exists(int'(mem_addr_o >> 5))) mem_data_i = dram[int'(mem_addr_o >> 5)];
                else mem_data_i = init_line(mem_addr_o);
            end
        end
    end

    // Reference model: per-index tag/valid/dirty, plus word values held only by dirty lines.
    logic        mvalid [32];
    logic        mdirty [32];
    logic [21:0] mtag   [32];
    logic [31:0] pend   [int];
    logic [31:0] refmem [int];

    function automatic logic [31:0] expect_word(input logic [31:0] a);
        if (pend.exists(int'(a))) return pend[int'(a)];
        if (refmem.exists(int'(a))) return refmem[int'(a)];
        return init_word(a);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mvalid[i] = 1'b0;
            mdirty[i] = 1'b0;
        end
        pend.delete();
    endtask

    // Expected timeline of the current operation, indexed by cycle k from its first cycle.
    bit           active = 1'b0;
    bit           idle_kind = 1'b0;
    bit           c_wb = 1'b0;
    bit           c_read = 1'b0;
    int           c_S = 0;
    int           c_L = 0;
    int           c_k = 0;
    logic [31:0]  c_exp_data = '0;
    logic [31:0]  c_victim_addr = '0;
    logic [31:0]  c_req_addr = '0;
    logic [255:0] c_victim_line = '0;
    logic [31:0]  seen_wb_addr = '0;
    logic [31:0]  seen_alloc_addr = '0;
    logic [255:0] seen_wb_data = '0;
    logic [31:0]  seen_rdata = '0;
    int           seen_stall = 0;

    always @(negedge clk_i) begin : compare
        logic         e_stall, e_en, e_wr;
        logic [31:0]  e_addr, e_data;
        logic [255:0] e_mdata;
        int           rs;
        if (active) begin
            rs = c_wb ? c_L + 1 : 1;
            e_stall = !idle_kind && (c_k < c_S);
            e_en = 1'b0;
            e_wr = 1'b0;
            e_addr = '0;
            e_mdata = '0;
            if (!idle_kind && c_S > 0) begin
                if (c_wb && c_k >= 1 && c_k <= c_L) begin
                    e_en = 1'b1;
                    e_wr = 1'b1;
                    e_addr = c_victim_addr;
                    e_mdata = c_victim_line;
                end else if (c_k >= rs && c_k < rs + c_L) begin
                    e_en = 1'b1;
                    e_addr = c_req_addr;
                end
            end
            e_data = (!idle_kind && c_read && c_k == c_S) ? c_exp_data : 32'h0;
            chk("stall", p1_stall_o, e_stall);
            chk("mem_enable", mem_enable_o, e_en);
            chk("mem_write", mem_write_o, e_wr);
            chk("mem_addr", mem_addr_o, e_addr);
            chk("mem_data", mem_data_o, e_mdata);
            chk("p1_data", p1_data_o, e_data);
            if (p1_stall_o) seen_stall++;
            if (c_wb && c_k == 1) begin
                seen_wb_addr = mem_addr_o;
                seen_wb_data = mem_data_o;
            end
            if (c_S > 0 && c_k == rs) seen_alloc_addr = mem_addr_o;
            if (c_k == c_S) begin
                seen_rdata = p1_data_o;
                active = 1'b0;
            end else begin
                c_k++;
            end
        end
    end

    task automatic wait_done(input string name);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk_i);
            #1;
            if (!active) break;
        end
        if (active) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout: operation still running at cycle k=%0d, required end at k=%0d",
                     name, c_k, c_S);
            active = 1'b0;
        end
    endtask

    task automatic access(input string name, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] d);
        int          idx;
        logic [21:0] tg;
        bit          hit;
        logic [31:0] va;
        @(posedge clk_i);
        #1;
        p1_MemRead_i = rd;
        p1_MemWrite_i = wr;
        p1_addr_i = a;
        p1_data_i = d;
        idx = int'(a[9:5]);
        tg = a[31:10];
        hit = mvalid[idx] && (mtag[idx] == tg);
        c_wb = 1'b0;
        c_L = lat;
        c_req_addr = {a[31:5], 5'b00000};
        seen_wb_addr = '0;
        seen_wb_data = '0;
        seen_alloc_addr = '0;
        if (!hit) begin
            if (mvalid[idx] && mdirty[idx]) begin
                c_wb = 1'b1;
                c_victim_addr = {mtag[idx], a[9:5], 5'b00000};
                for (int w = 0; w < 8; w++) begin
                    va = c_victim_addr + 32'(4 * w);
                    c_victim_line[32*w +: 32] = expect_word(va);
                    if (pend.exists(int'(va))) begin
                        refmem[int'(va)] = pend[int'(va)];
                        pend.delete(int'(va));
                    end
                end
            end
            mvalid[idx] = 1'b1;
            mtag[idx] = tg;
            mdirty[idx] = 1'b0;
            c_S = c_wb ? 2 * lat + 2 : lat + 2;
        end else begin
            c_S = 0;
        end
        if (wr) begin
            pend[int'(a & ~32'h3)] = d;
            mdirty[idx] = 1'b1;
        end
        c_read = rd && !wr;
        c_exp_data = expect_word(a & ~32'h3);
        idle_kind = 1'b0;
        c_k = 0;
        seen_stall = 0;
        active = 1'b1;
        wait_done(name);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #2;
        rst_i = 1'b0;
        #10;
        chk("reset_stall", p1_stall_o, 1'b0);
        chk("reset_p1_data", p1_data_o, 32'h0);
        chk("reset_mem_enable", mem_enable_o, 1'b0);
        chk("reset_mem_write", mem_write_o, 1'b0);
        chk("reset_mem_addr", mem_addr_o, 32'h0);
        chk("reset_mem_data", mem_data_o, 256'h0);
        #3;
        rst_i = 1'b1;

        // Clean read miss with a 10-cycle memory.
        lat = 10;
        access("t1", 1, 0, 32'h0000_0404, 0);
        chk("t1_stall_cycles", seen_stall, 12);
        chk("t1_alloc_addr", seen_alloc_addr, 32'h400);
        chk("t1_rdata", seen_rdata, 32'hDEAD_BEEF);

        // Write hit then read hit.
        lat = 3;
        access("t2w", 0, 1, 32'h0000_0408, 32'h1234_5678);
        chk("t2_write_stall_cycles", seen_stall, 0);
        access("t2r", 1, 0, 32'h0000_0408, 0);
        chk("t2_read_stall_cycles", seen_stall, 0);
        chk("t2_rdata", seen_rdata, 32'h1234_5678);

        // Dirty conflict miss on index 0.
        access("t3", 1, 0, 32'h0000_0808, 0);
        chk("t3_stall_cycles", seen_stall, 8);
        chk("t3_wb_addr", seen_wb_addr, 32'h400);
        chk("t3_wb_word2", seen_wb_data[95:64], 32'h1234_5678);
        chk("t3_alloc_addr", seen_alloc_addr, 32'h800);

        // Write miss on an invalid line, then read hit, then eviction shows the dirty word.
        access("t4w", 0, 1, 32'h0000_0024, 32'hA5A5_A5A5);
        chk("t4_stall_cycles", seen_stall, 5);
        chk("t4_alloc_addr", seen_alloc_addr, 32'h20);
        access("t4r", 1, 0, 32'h0000_0024, 0);
        chk("t4_read_stall_cycles", seen_stall, 0);
        chk("t4_rdata", seen_rdata, 32'hA5A5_A5A5);
        access("t4e", 1, 0, 32'h0000_0424, 0);
        chk("t4_wb_addr", seen_wb_addr, 32'h20);
        chk("t4_wb_word1", seen_wb_data[63:32], 32'hA5A5_A5A5);

        // Reset in the fourth ALLOCATE cycle of a clean miss.
        lat = 10;
        @(posedge clk_i);
        #1;
        p1_MemRead_i = 1'b1;
        p1_MemWrite_i = 1'b0;
        p1_addr_i = 32'h0000_0044;
        repeat (5) @(negedge clk_i);
        #1;
        chk("t5_enable_before_reset", mem_enable_o, 1'b1);
        rst_i = 1'b0;
        #1;
        chk("t5_enable_async", mem_enable_o, 1'b0);
        chk("t5_stall_async", p1_stall_o, 1'b0);
        chk("t5_addr_async", mem_addr_o, 32'h0);
        model_reset();
        p1_MemRead_i = 1'b0;
        @(posedge clk_i);
        #3;
        rst_i = 1'b1;
        access("t5r", 1, 0, 32'h0000_0044, 0);
        chk("t5_miss_again_stall", seen_stall, 12);
        chk("t5_rdata", seen_rdata, 32'h0F4B_FFBB);

        // Idle window with a spurious ack; the line must still hit afterwards.
        lat = 3;
        @(posedge clk_i);
        #1;
        p1_MemRead_i = 1'b0;
        p1_MemWrite_i = 1'b0;
        idle_kind = 1'b1;
        c_S = 19;
        c_k = 0;
        seen_stall = 0;
        active = 1'b1;
        repeat (5) @(negedge clk_i);
        #2;
        spur_ack = 1'b1;
        @(negedge clk_i);
        #2;
        spur_ack = 1'b0;
        wait_done("t6_idle");
        chk("t6_idle_stall_cycles", seen_stall, 0);
        access("t6r", 1, 0, 32'h0000_0044, 0);
        chk("t6_read_stall_cycles", seen_stall, 0);
        chk("t6_rdata", seen_rdata, 32'h0F4B_FFBB);

        @(posedge clk_i);
        #1;
        p1_MemRead_i = 1'b0;
        p1_MemWrite_i = 1'b0;
        repeat (2) @(posedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
